// File: rtl/rx_ipd_monitor.sv
// Zero-latency AXI4-Stream tap that measures inter-packet gaps in utimer ticks and
// accumulates packet, byte, pacing-violation and length-error statistics.
module rx_ipd_monitor #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic                              utimer_clk,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     IPD_value,
  input  logic                              stats_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     last_ipd,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     min_ipd,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     max_ipd,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     byte_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ipd_violations,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     len_errors,
  output logic                              ipd_valid
);

  localparam int unsigned StrbW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned W     = C_S_AXI_DATA_WIDTH;
  localparam logic [W-1:0] One  = W'(1);

  typedef enum logic [1:0] {StIdle, StInPkt, StGap} state_e;

  state_e         state_q;
  logic           discard_q;
  logic           ipd_valid_q;
  logic [W-1:0]   gap_cnt_q, last_ipd_q, min_ipd_q, max_ipd_q;
  logic [W-1:0]   pkt_count_q, byte_count_q, ipd_viol_q, len_err_q;
  logic [15:0]    len_acc_q, len_exp_q;

  logic           beat, sop, eop, frame_open;
  logic [15:0]    beat_bytes, len_sum, len_exp;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tlast  = s_axis_tlast;
  assign s_axis_tready = m_axis_tready;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < StrbW; i++) begin
      beat_bytes = beat_bytes + {15'd0, s_axis_tstrb[i]};
    end
  end

  assign beat    = s_axis_tvalid & m_axis_tready;
  assign sop     = beat & ~discard_q & (state_q != StInPkt);
  assign eop     = beat & s_axis_tlast & ~discard_q;
  assign len_sum = sop ? beat_bytes : len_acc_q + beat_bytes;
  assign len_exp = sop ? s_axis_tuser[15:0] : len_exp_q;
  // A packet is still open on the wire after this cycle (tracked or being discarded).
  assign frame_open = beat ? ~s_axis_tlast : ((state_q == StInPkt) | discard_q);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= StIdle;
      discard_q    <= 1'b0;
      ipd_valid_q  <= 1'b0;
      gap_cnt_q    <= '0;
      last_ipd_q   <= '0;
      min_ipd_q    <= '1;
      max_ipd_q    <= '0;
      pkt_count_q  <= '0;
      byte_count_q <= '0;
      ipd_viol_q   <= '0;
      len_err_q    <= '0;
      len_acc_q    <= '0;
      len_exp_q    <= '0;
    end else if (stats_clear) begin
      state_q      <= StIdle;
      discard_q    <= frame_open;
      ipd_valid_q  <= 1'b0;
      gap_cnt_q    <= '0;
      last_ipd_q   <= '0;
      min_ipd_q    <= '1;
      max_ipd_q    <= '0;
      pkt_count_q  <= '0;
      byte_count_q <= '0;
      ipd_viol_q   <= '0;
      len_err_q    <= '0;
      len_acc_q    <= '0;
      len_exp_q    <= '0;
    end else begin
      ipd_valid_q <= 1'b0;
      if (discard_q && beat && s_axis_tlast) discard_q <= 1'b0;

      case (state_q)
        StIdle, StGap: if (sop) state_q <= s_axis_tlast ? StGap : StInPkt;
        StInPkt:       if (eop) state_q <= StGap;
        default:       state_q <= StIdle;
      endcase

      // Neither the EOP nor the SOP acceptance cycle contributes a tick.
      if (eop) begin
        gap_cnt_q <= '0;
      end else if (state_q == StGap && !sop && utimer_clk && gap_cnt_q != '1) begin
        gap_cnt_q <= gap_cnt_q + One;
      end

      if (sop) begin
        pkt_count_q  <= pkt_count_q + One;
        byte_count_q <= byte_count_q + {{(W-16){1'b0}}, s_axis_tuser[15:0]};
        len_exp_q    <= s_axis_tuser[15:0];
      end

      if (sop && state_q == StGap) begin
        last_ipd_q  <= gap_cnt_q;
        ipd_valid_q <= 1'b1;
        if (gap_cnt_q < min_ipd_q) min_ipd_q <= gap_cnt_q;
        if (gap_cnt_q > max_ipd_q) max_ipd_q <= gap_cnt_q;
        if (gap_cnt_q < IPD_value) ipd_viol_q <= ipd_viol_q + One;
      end

      if (beat && !discard_q) len_acc_q <= len_sum;
      if (eop && len_sum != len_exp) len_err_q <= len_err_q + One;
    end
  end

  assign last_ipd       = last_ipd_q;
  assign min_ipd        = min_ipd_q;
  assign max_ipd        = max_ipd_q;
  assign pkt_count      = pkt_count_q;
  assign byte_count     = byte_count_q;
  assign ipd_violations = ipd_viol_q;
  assign len_errors     = len_err_q;
  assign ipd_valid      = ipd_valid_q;

endmodule

// File: tb/tb_rx_ipd_monitor.sv
// Randomised bench for rx_ipd_monitor: a transaction-level model predicts every IPD sample
// into a scoreboard that a negedge monitor drains, plus statistics checks per scenario.
module tb_rx_ipd_monitor;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned AW = 32;

  logic          axi_aclk, axi_resetn, utimer_clk;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [SW-1:0] s_axis_tstrb, m_axis_tstrb;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [AW-1:0] ipd_value;
  logic          stats_clear;
  logic [AW-1:0] last_ipd, min_ipd, max_ipd, pkt_count, byte_count, ipd_violations, len_errors;
  logic          ipd_valid;

  rx_ipd_monitor #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .C_S_AXI_DATA_WIDTH  (AW)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .utimer_clk    (utimer_clk),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .IPD_value     (ipd_value),
    .stats_clear   (stats_clear),
    .last_ipd      (last_ipd),
    .min_ipd       (min_ipd),
    .max_ipd       (max_ipd),
    .pkt_count     (pkt_count),
    .byte_count    (byte_count),
    .ipd_violations(ipd_violations),
    .len_errors    (len_errors),
    .ipd_valid     (ipd_valid)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [31:0] ipd;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] viol;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  bit   tick_all = 1'b1;

  // Reference model state (transaction level)
  logic [31:0] md_last, md_min, md_max, md_viol, md_pkt, md_bytes, md_lenerr, md_gap;
  bit          md_gap_open, md_discard;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic bit tickv();
    return tick_all ? 1'b1 : ($urandom_range(1) == 1);
  endfunction

  task automatic model_clear();
    md_last = '0; md_min = '1; md_max = '0; md_viol = '0;
    md_pkt = '0; md_bytes = '0; md_lenerr = '0; md_gap = '0;
    md_gap_open = 1'b0; md_discard = 1'b0;
  endtask

  task automatic model_sop(input logic [15:0] len);
    if (md_gap_open) begin
      md_last = md_gap;
      if (md_gap < md_min) md_min = md_gap;
      if (md_gap > md_max) md_max = md_gap;
      if (md_gap < ipd_value) md_viol++;
      sb_q.push_back('{ipd: md_last, mn: md_min, mx: md_max, viol: md_viol});
    end
    md_pkt++;
    md_bytes = md_bytes + {16'd0, len};
  endtask

  task automatic model_eop(input int sum, input logic [15:0] len);
    if (sum[15:0] != len) md_lenerr++;
    md_gap_open = 1'b1;
    md_gap = '0;
  endtask

  task automatic cyc(input bit v, input bit r, input bit l, input logic [SW-1:0] strb,
                     input logic [15:0] len, input bit tk, input bit clr);
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
    for (int i = 0; i < int'(UW / 32); i++) u[i*32 +: 32] = $urandom;
    u[15:0] = len;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tstrb = strb;
    s_axis_tvalid = v; s_axis_tlast = l; m_axis_tready = r;
    utimer_clk = tk; stats_clear = clr;
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic gap(input int n);
    bit tk;
    for (int i = 0; i < n; i++) begin
      tk = tickv();
      if (md_gap_open && tk) md_gap = sat_inc(md_gap);
      cyc(1'b0, ($urandom_range(1) == 1), ($urandom_range(1) == 1), SW'($urandom),
          16'($urandom), tk, 1'b0);
    end
  endtask

  task automatic send_pkt(input int nb, input logic [15:0] len, input logic [SW-1:0] strb_last,
                          input int stall_beat, input int stall_n, input int clear_beat,
                          input int abort_beat);
    int sum;
    bit last, tk;
    logic [SW-1:0] strb;
    sum = 0;
    for (int b = 0; b < nb; b++) begin
      last = (b == nb - 1);
      strb = last ? strb_last : '1;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          tk = tickv();
          if (b == 0 && md_gap_open && tk) md_gap = sat_inc(md_gap);
          cyc(1'b1, 1'b0, last, strb, len, tk, 1'b0);
          chk("stall_tready", {31'd0, s_axis_tready}, 32'd0);
          chk("stall_pkt_count", pkt_count, md_pkt);
        end
      end
      tk = tickv();
      if (b == clear_beat) begin
        model_clear();
        md_discard = !last;
        cyc(1'b1, 1'b1, last, strb, len, tk, 1'b1);
      end else if (md_discard) begin
        if (last) md_discard = 1'b0;
        cyc(1'b1, 1'b1, last, strb, len, tk, 1'b0);
      end else begin
        if (b == 0) model_sop(len);
        sum += $countones(strb);
        if (last) model_eop(sum, len);
        cyc(1'b1, 1'b1, last, strb, len, tk, 1'b0);
      end
      if (b == abort_beat) return;
    end
  endtask

  task automatic pkt1(input logic [15:0] len);
    send_pkt(1, len, '1, -1, 0, -1, -1);
  endtask

  task automatic clear_idle();
    model_clear();
    cyc(1'b0, 1'b1, 1'b0, '0, 16'd0, tickv(), 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_last_ipd"}, last_ipd, 32'd0);
    chk({tag, "_min_ipd"}, min_ipd, 32'hFFFF_FFFF);
    chk({tag, "_max_ipd"}, max_ipd, 32'd0);
    chk({tag, "_pkt_count"}, pkt_count, 32'd0);
    chk({tag, "_byte_count"}, byte_count, 32'd0);
    chk({tag, "_ipd_viol"}, ipd_violations, 32'd0);
    chk({tag, "_len_errors"}, len_errors, 32'd0);
    chk({tag, "_ipd_valid"}, {31'd0, ipd_valid}, 32'd0);
  endtask

  // Scoreboard monitor and pass-through checker
  always @(negedge axi_aclk) begin
    exp_t e;
    if (axi_resetn) begin
      n_checks++;
      if (m_axis_tdata !== s_axis_tdata || m_axis_tstrb !== s_axis_tstrb ||
          m_axis_tuser !== s_axis_tuser || m_axis_tvalid !== s_axis_tvalid ||
          m_axis_tlast !== s_axis_tlast || s_axis_tready !== m_axis_tready) begin
        n_fail++;
        $display("FAIL passthrough: got m_tvalid=%b m_tlast=%b s_tready=%b, expected %b %b %b",
                 m_axis_tvalid, m_axis_tlast, s_axis_tready, s_axis_tvalid, s_axis_tlast,
                 m_axis_tready);
      end
      if (ipd_valid === 1'b1) begin
        n_pulses++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ipd_valid_unexpected: got pulse, expected none (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_last_ipd", last_ipd, e.ipd);
          chk("sb_min_ipd", min_ipd, e.mn);
          chk("sb_max_ipd", max_ipd, e.mx);
          chk("sb_ipd_viol", ipd_violations, e.viol);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, nb, sb, cb;
    logic [SW-1:0] sl;
    logic [15:0] len;
    axi_resetn = 1'b0; utimer_clk = 1'b0; stats_clear = 1'b0; ipd_value = '0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    model_clear();
    #12;
    chk_reset("por");
    @(negedge axi_aclk); axi_resetn = 1'b1;
    @(posedge axi_aclk); #1;

    // Two single-beat packets 10 ticks apart
    tick_all = 1'b1;
    p0 = n_pulses;
    pkt1(16'd32); gap(10); pkt1(16'd32); gap(2);
    chk("t1_last_ipd", last_ipd, 32'd10);
    chk("t1_min_ipd", min_ipd, 32'd10);
    chk("t1_max_ipd", max_ipd, 32'd10);
    chk("t1_pkt_count", pkt_count, 32'd2);
    chk("t1_byte_count", byte_count, 32'd64);
    chk("t1_len_errors", len_errors, 32'd0);
    chk("t1_pulses", 32'(n_pulses - p0), 32'd1);

    // Pacing violations
    clear_idle();
    ipd_value = 32'd20;
    pkt1(16'd32); gap(25); pkt1(16'd32); gap(15); pkt1(16'd32); gap(2);
    chk("t2_viol", ipd_violations, 32'd1);
    chk("t2_min_ipd", min_ipd, 32'd15);
    chk("t2_max_ipd", max_ipd, 32'd25);
    chk("t2_last_ipd", last_ipd, 32'd15);

    // Length checking across three beats
    clear_idle();
    ipd_value = '0;
    send_pkt(3, 16'd70, SW'(32'h3F), -1, 0, -1, -1); gap(2);
    chk("t3_len_ok", len_errors, 32'd0);
    send_pkt(3, 16'd70, SW'(32'h0F), -1, 0, -1, -1); gap(2);
    chk("t3_len_bad", len_errors, 32'd1);
    chk("t3_pkt_count", pkt_count, 32'd2);

    // Stalls: ticks count while SOP waits in the gap, not mid-packet
    clear_idle();
    pkt1(16'd32); gap(4);
    send_pkt(3, 16'd96, '1, 0, 3, -1, -1);
    send_pkt(3, 16'd96, '1, 1, 5, -1, -1); gap(2);
    chk("t4_last_ipd", last_ipd, 32'd0);
    chk("t4_max_ipd", max_ipd, 32'd7);
    chk("t4_min_ipd", min_ipd, 32'd0);
    chk("t4_pkt_count", pkt_count, 32'd3);

    // Clear on the middle beat discards the rest of that packet
    clear_idle();
    pkt1(16'd32); gap(3);
    send_pkt(3, 16'd96, '1, -1, 0, 1, -1);
    gap(5); pkt1(16'd32); gap(6); pkt1(16'd32); gap(2);
    chk("t5_pkt_count", pkt_count, 32'd2);
    chk("t5_byte_count", byte_count, 32'd64);
    chk("t5_min_ipd", min_ipd, 32'd6);
    chk("t5_max_ipd", max_ipd, 32'd6);

    // Gap counter saturation
    clear_idle();
    pkt1(16'd32); gap(3);
    force dut.gap_cnt_q = 32'hFFFF_FFFF;
    md_gap = 32'hFFFF_FFFF;
    @(negedge axi_aclk);
    release dut.gap_cnt_q;
    gap(3); pkt1(16'd32); gap(2);
    chk("t6_last_sat", last_ipd, 32'hFFFF_FFFF);
    chk("t6_max_sat", max_ipd, 32'hFFFF_FFFF);

    // Async reset mid-packet
    gap(2);
    send_pkt(3, 16'd96, '1, -1, 0, -1, 0);
    @(negedge axi_aclk);
    #2;
    axi_resetn = 1'b0;
    #1;
    chk_reset("async");
    model_clear();
    cyc(1'b0, 1'b1, 1'b0, '0, 16'd0, 1'b1, 1'b0);
    @(negedge axi_aclk); axi_resetn = 1'b1;
    @(posedge axi_aclk); #1;

    // Randomised traffic
    tick_all = 1'b0;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(7) == 0) ipd_value = 32'($urandom_range(8));
      gap($urandom_range(12));
      nb  = $urandom_range(4, 1);
      sl  = SW'($urandom);
      len = 16'(32 * (nb - 1) + $countones(sl));
      if ($urandom_range(3) == 0) len = len + 16'($urandom_range(3, 1));
      sb  = $urandom_range(5);
      cb  = ($urandom_range(9) == 0) ? $urandom_range(nb - 1) : -1;
      send_pkt(nb, len, sl, sb, $urandom_range(4, 1), cb, -1);
    end
    gap(3);
    chk("rnd_pkt_count", pkt_count, md_pkt);
    chk("rnd_byte_count", byte_count, md_bytes);
    chk("rnd_len_errors", len_errors, md_lenerr);
    chk("rnd_ipd_viol", ipd_violations, md_viol);
    chk("rnd_min_ipd", min_ipd, md_min);
    chk("rnd_max_ipd", max_ipd, md_max);
    chk("rnd_last_ipd", last_ipd, md_last);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
